// File: rtl/sram.sv
// ---------------------------------------------------------------------------
// sram
// Single-port synchronous SRAM model (64 x 8 by default), used as the memory
// under test for the MBIST subsystem.
//
// Ports:
//   clk      - system clock, rising-edge active
//   rst_n    - asynchronous active-low reset; clears address register and
//              every memory word
//   ramaddr  - word address, captured on every selected rising edge
//   ramin    - write data
//   rwbar    - 1 = read, 0 = write
//   cs       - chip select, active high
//   ramout   - read data, combinational from the registered address; zero
//              when deselected or in write mode
// ---------------------------------------------------------------------------
module sram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ramaddr,
  input  logic [DATA_WIDTH-1:0] ramin,
  input  logic                  rwbar,
  input  logic                  cs,
  output logic [DATA_WIDTH-1:0] ramout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_reg;

  // The whole array is cleared on reset so the read path can never return X.
  // The address is captured in both modes, so a read right after a write
  // returns the word just written without another edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (cs) begin
      addr_reg <= ramaddr;
      if (!rwbar) begin
        mem[ramaddr] <= ramin;
      end
    end
  end

  // Only the registered address selects the word; ramaddr changes between
  // edges have no effect on the output.
  always_comb begin
    ramout = '0;
    if (cs && rwbar) begin
      ramout = mem[addr_reg];
    end
  end

endmodule

// File: tb/tb_sram.sv
// ---------------------------------------------------------------------------
// tb_sram
// Directed self-checking bench for sram. Inputs change on the falling edge,
// outputs are sampled 1 ns after the rising edge or 1 ns after a
// combinational input change.
// ---------------------------------------------------------------------------
module tb_sram;

  logic       clk;
  logic       rst_n;
  logic [5:0] ramaddr;
  logic [7:0] ramin;
  logic       rwbar;
  logic       cs;
  logic [7:0] ramout;

  int checks;
  int errors;

  sram #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(8),
    .DEPTH(64)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ramaddr(ramaddr),
    .ramin  (ramin),
    .rwbar  (rwbar),
    .cs     (cs),
    .ramout (ramout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs at the falling edge, then let one rising edge
  // act on them and settle 1 ns past it.
  task automatic applyStimulus(input logic [5:0] addr, input logic [7:0] data,
                               input logic rw, input logic sel);
    @(negedge clk);
    ramaddr = addr;
    ramin   = data;
    rwbar   = rw;
    cs      = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    checks++;
    assert (ramout === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, ramout, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    cs      = 1'b0;
    rwbar   = 1'b1;
    ramaddr = '0;
    ramin   = '0;

    // Reset state: deselected, then selected in read mode while held in reset
    #12;
    checkOutput("reset_deselected", 8'h00);
    cs = 1'b1;
    #1;
    checkOutput("reset_selected_read", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // First read after reset at address 0
    applyStimulus(6'd0, 8'h00, 1'b1, 1'b1);
    checkOutput("read_addr0_after_reset", 8'h00);

    // Write 0xA5 @10, then flip to read with a different ramaddr and no edge
    applyStimulus(6'd10, 8'hA5, 1'b0, 1'b1);
    checkOutput("write_mode_output_zero", 8'h00);
    rwbar   = 1'b1;
    ramaddr = 6'd5;
    #1;
    checkOutput("read_registered_addr10", 8'hA5);

    // Write 0x3C @20, output zero in write mode, then same-cycle read
    applyStimulus(6'd20, 8'h3C, 1'b0, 1'b1);
    checkOutput("write20_output_zero", 8'h00);
    rwbar = 1'b1;
    #1;
    checkOutput("read_back_addr20", 8'h3C);

    // Chip select gating without a clock edge
    cs      = 1'b0;
    ramaddr = 6'd20;
    #1;
    checkOutput("cs_low_gates_output", 8'h00);
    cs = 1'b1;
    #1;
    checkOutput("cs_restored_addr20", 8'h3C);

    // Address boundaries
    applyStimulus(6'd63, 8'h11, 1'b0, 1'b1);
    applyStimulus(6'd0,  8'h22, 1'b0, 1'b1);
    applyStimulus(6'd63, 8'h00, 1'b1, 1'b1);
    checkOutput("read_addr63", 8'h11);
    applyStimulus(6'd0,  8'h00, 1'b1, 1'b1);
    checkOutput("read_addr0", 8'h22);
    applyStimulus(6'd10, 8'h00, 1'b1, 1'b1);
    checkOutput("read_addr10_retained", 8'hA5);

    // Deselected edge: no write and address register holds (stays at 10)
    applyStimulus(6'd30, 8'hFF, 1'b0, 1'b0);
    cs    = 1'b1;
    rwbar = 1'b1;
    #1;
    checkOutput("addr_reg_holds_when_deselected", 8'hA5);
    applyStimulus(6'd30, 8'h00, 1'b1, 1'b1);
    checkOutput("no_write_when_deselected", 8'h00);

    // Write 0x5A @7, confirm it, then reset mid-cycle
    applyStimulus(6'd7, 8'h5A, 1'b0, 1'b1);
    rwbar = 1'b1;
    #1;
    checkOutput("read_back_addr7", 8'h5A);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_clears_immediately", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(6'd7, 8'h00, 1'b1, 1'b1);
    checkOutput("addr7_cleared_by_reset", 8'h00);
    applyStimulus(6'd10, 8'h00, 1'b1, 1'b1);
    checkOutput("addr10_cleared_by_reset", 8'h00);
    applyStimulus(6'd63, 8'h00, 1'b1, 1'b1);
    checkOutput("addr63_cleared_by_reset", 8'h00);

    // Memory still writable after reset
    applyStimulus(6'd33, 8'hC3, 1'b0, 1'b1);
    applyStimulus(6'd34, 8'h96, 1'b0, 1'b1);
    applyStimulus(6'd33, 8'h00, 1'b1, 1'b1);
    checkOutput("read_addr33_after_reset", 8'hC3);
    applyStimulus(6'd34, 8'h00, 1'b1, 1'b1);
    checkOutput("read_addr34_after_reset", 8'h96);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram.md
Name: sram

Overview:
- Single-port synchronous SRAM model, 64 words x 8 bits, used as the memory under test in the MBIST subsystem.
- Writes occur on the rising clock edge.
- The read address is registered on the rising edge; read data is driven combinationally from the registered address, gated by chip-select and read mode.
- Output is forced to zero whenever the block is not selected or is in write mode.

Parameters:
- ADDR_WIDTH, 6, address bus width.
- DATA_WIDTH, 8, data word width.
- DEPTH, 64, number of words (2**ADDR_WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- ramaddr  input  ADDR_WIDTH  word address.
- ramin  input  DATA_WIDTH  write data.
- rwbar  input  1  1 = read, 0 = write.
- cs  input  1  chip select, active high.
- ramout  output  DATA_WIDTH  read data.

Behaviour:
- Storage: array mem[0..DEPTH-1] of DATA_WIDTH bits, plus an address register addr_reg (ADDR_WIDTH bits).
- Reset: rst_n low immediately (asynchronously) clears addr_reg to 0 and every mem word to 0.
  - While rst_n is low, no writes occur and addr_reg stays 0.
  - ramout follows the combinational rule below; after reset it reads 0 for all addresses.
  - Deassertion takes effect at the next rising edge.
- Rising edge of clk with rst_n high and cs=1:
  - addr_reg <= ramaddr (in both read and write mode).
  - If rwbar=0: mem[ramaddr] <= ramin.
- Rising edge with cs=0: no write, addr_reg holds its value.
- Output (combinational, no clock): ramout = mem[addr_reg] when cs=1 and rwbar=1; otherwise ramout = 0.
  - ramaddr changes without a clock edge do not affect ramout. Only addr_reg selects the word.
  - Immediately after a write edge, switching rwbar to 1 returns the just-written word, with zero additional cycles.
- Read latency: one rising edge to capture the address. Data is valid combinationally after that edge, and also in the same cycle if cs or rwbar change afterwards.
- Simultaneous write and read of the same address: not possible in one cycle (single port). On the write edge, addr_reg takes the write address, so a subsequent read with rwbar=1 returns the new data.
- Address range: full 0..63; no out-of-range handling needed. Address wraps naturally with the bus width.
- Reset mid-write: an asserting rst_n wins over a concurrent clock edge; that write is lost and memory is cleared.
- Unknown handling: ramout must never be X after reset, because every word is initialized.

Test Plan:
- Reset, then cs=1, rwbar=1, clock one edge at ramaddr=0 -> ramout=0x00.
- Write 0xA5 at addr 10 (cs=1, rwbar=0, edge); then rwbar=1 and ramaddr=5 with no edge -> ramout=0xA5 (registered address used).
- Write 0x3C at addr 20; 1 ns after the edge with rwbar still 0 -> ramout=0x00; then rwbar=1 with no edge -> ramout=0x3C.
- Next, with rwbar=1, cs=0, ramaddr=20 -> ramout=0x00; restore cs=1 -> ramout=0x3C.
- Write 0x11 at addr 63 and 0x22 at addr 0; read addr 63 (edge) -> 0x11; read addr 0 (edge) -> 0x22. This checks the address boundaries.
- Write 0x5A at addr 7; assert rst_n low mid-cycle -> ramout=0x00 immediately; release rst_n, read addr 7 -> 0x00.
